// File: rtl/spi_cmd_master.sv
// rtl/spi_cmd_master.sv - SPI command master: cmd byte, data byte, optional read byte
module spi_cmd_master #(
    parameter int CLK_DIV = 2,
    parameter int GAP_SCK = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_cmd,
    input  logic [7:0] req_data,
    input  logic       req_read,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SCK,
    output logic       SSB,
    output logic       MOSI,
    input  logic       MISO
);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (GAP_SCK > 8) ? GAP_SCK : 8;
    localparam int CW      = $clog2(CNT_MAX);

    typedef enum logic [2:0] {IDLE, SHIFT, GAP, RDSHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic            sck_q, sck_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      byte_q, byte_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      data_q, data_d;
    logic            read_q, read_d;
    logic [7:0]      rsp_data_q, rsp_data_d;

    logic            wrap;
    logic            sck_rise;
    logic            sck_fall;

    assign wrap     = (div_q == DW'(CLK_DIV - 1));
    assign sck_rise = wrap && !sck_q;
    assign sck_fall = wrap && sck_q;

    // State and datapath registers; reset returns the bus to idle even mid-transfer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            sck_q      <= 1'b0;
            cnt_q      <= '0;
            byte_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_q     <= '0;
            read_q     <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            sck_q      <= sck_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_q     <= data_d;
            read_q     <= read_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Next-state: SCK runs through SHIFT/GAP/RDSHIFT; every phase ends on an SCK falling edge
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sck_d      = sck_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_d     = data_q;
        read_d     = read_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = SHIFT;
                    tx_d    = {4'b0000, req_cmd};
                    data_d  = req_data;
                    read_d  = req_read;
                    div_d   = '0;
                    sck_d   = 1'b0;
                    cnt_d   = '0;
                    byte_d  = '0;
                    rx_d    = '0;
                end
            end
            SHIFT, RDSHIFT, GAP: begin
                div_d = wrap ? '0 : div_q + 1'b1;
                if (wrap) begin
                    sck_d = ~sck_q;
                end
                // MISO is taken at the clk edge that raises SCK, i.e. its pre-edge value
                if (sck_rise && state_q == RDSHIFT) begin
                    rx_d = {rx_q[6:0], MISO};
                end
                if (sck_fall) begin
                    if (state_q == GAP) begin
                        if (cnt_q == CW'(GAP_SCK - 1)) begin
                            cnt_d = '0;
                            if (byte_q == 2'd1) begin
                                state_d = SHIFT;
                                tx_d    = data_q;
                            end else if (byte_q == 2'd2 && read_q) begin
                                state_d = RDSHIFT;
                            end else begin
                                state_d    = DONE;
                                rsp_data_d = read_q ? rx_q : 8'h00;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        if (cnt_q == CW'(7)) begin
                            state_d = GAP;
                            cnt_d   = '0;
                            byte_d  = byte_q + 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                sck_d   = 1'b0;
                div_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = ~req_ready;
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = rsp_data_q;
    assign SCK       = sck_q;
    assign SSB       = !((state_q == SHIFT) || (state_q == RDSHIFT));
    assign MOSI      = (state_q == SHIFT) && tx_q[7];
endmodule

// File: tb/tb_spi_cmd_master.sv
// tb/tb_spi_cmd_master.sv - randomized self-checking bench for spi_cmd_master
module tb_spi_cmd_master;
    localparam int D  = 2;
    localparam int G  = 4;
    localparam int FD = 1;
    localparam int FG = 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid, req_ready, req_read, rsp_valid, busy, SCK, SSB, MOSI, MISO;
    logic [3:0] req_cmd;
    logic [7:0] req_data, rsp_data;

    logic       f_req_valid, f_req_ready, f_req_read, f_rsp_valid, f_busy, f_SCK, f_SSB, f_MOSI;
    logic [3:0] f_req_cmd;
    logic [7:0] f_req_data, f_rsp_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_cmd_master #(.CLK_DIV(D), .GAP_SCK(G)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_data(req_data), .req_read(req_read),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .SCK(SCK), .SSB(SSB), .MOSI(MOSI), .MISO(MISO)
    );

    spi_cmd_master #(.CLK_DIV(FD), .GAP_SCK(FG)) dut_fast (
        .clk(clk), .reset_n(reset_n), .req_valid(f_req_valid), .req_ready(f_req_ready),
        .req_cmd(f_req_cmd), .req_data(f_req_data), .req_read(f_req_read),
        .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data), .busy(f_busy),
        .SCK(f_SCK), .SSB(f_SSB), .MOSI(f_MOSI), .MISO(1'b0)
    );

    // Slave-side model: records MOSI per SSB-low frame and serves miso_byte MSB first
    logic [7:0] miso_byte = 8'h00;
    logic [7:0] cur = 8'h00;
    int         rc = 0;
    logic [7:0] frames[$];
    int         rises[$];
    logic       prev_sck = 1'b0, prev_ssb = 1'b1, f_prev_sck = 1'b0, f_prev_ssb = 1'b1;
    int         viol = 0, f_viol = 0;

    assign MISO = (rc < 8) ? miso_byte[7 - rc] : 1'b0;

    always @(posedge clk) begin
        #1;
        if (SSB === 1'b0 && SCK === 1'b1 && prev_sck === 1'b0) begin
            cur = {cur[6:0], MOSI};
            rc  = rc + 1;
        end
        if (SSB !== prev_ssb && SCK === 1'b1) viol = viol + 1;
        if (f_SSB !== f_prev_ssb && f_SCK === 1'b1) f_viol = f_viol + 1;
        if (SSB === 1'b1 && prev_ssb === 1'b0) begin
            frames.push_back(cur);
            rises.push_back(rc);
            cur = 8'h00;
            rc  = 0;
        end
        prev_sck = SCK;   prev_ssb = SSB;
        f_prev_sck = f_SCK; f_prev_ssb = f_SSB;
    end

    function automatic int exp_latency(input int div, input int gap, input logic rd);
        return 1 + (rd ? (24 + 3 * gap) : (16 + 2 * gap)) * 2 * div;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({SSB, SCK, MOSI, rsp_valid, req_ready, busy, rsp_data} !== {6'b100010, 8'h00}) begin
            bad++;
            $display("FAIL reset_state got ssb=%b sck=%b mosi=%b rv=%b rdy=%b busy=%b rd=%h want 1 0 0 0 1 0 00",
                     SSB, SCK, MOSI, rsp_valid, req_ready, busy, rsp_data);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One transaction on the default instance, checked against framing/latency rules
    task automatic run_txn(input logic [3:0] c, input logic [7:0] d, input logic r,
                           input logic [7:0] m, input string tag);
        int lat;
        logic [7:0] ef[$];
        ef.push_back({4'b0000, c});
        ef.push_back(d);
        if (r) ef.push_back(8'h00);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready_before got %b want 1", tag, req_ready);
        end
        miso_byte = m;
        frames.delete();
        rises.delete();
        req_valid = 1'b1; req_cmd = c; req_data = d; req_read = r;
        @(negedge clk);
        req_valid = 1'b0;
        req_cmd = 4'($urandom); req_data = 8'($urandom); req_read = 1'($urandom);
        total++;
        if ({SSB, SCK, MOSI} !== 3'b000) begin
            bad++;
            $display("FAIL %s_start got ssb/sck/mosi=%b%b%b want 000", tag, SSB, SCK, MOSI);
        end
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== exp_latency(D, G, r)) begin
            bad++;
            $display("FAIL %s_latency got %0d want %0d", tag, lat, exp_latency(D, G, r));
        end
        total++;
        if (rsp_data !== (r ? m : 8'h00) || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_rsp got data=%h ready=%b want data=%h ready=0",
                     tag, rsp_data, req_ready, r ? m : 8'h00);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_after got rv=%b ready=%b want 0 1", tag, rsp_valid, req_ready);
        end
        total++;
        if (frames.size() != ef.size()) begin
            bad++;
            $display("FAIL %s_frame_count got %0d want %0d", tag, frames.size(), ef.size());
        end else begin
            for (int i = 0; i < ef.size(); i++) begin
                if (frames[i] !== ef[i] || rises[i] != 8) begin
                    bad++;
                    $display("FAIL %s_frame%0d got byte=%h rises=%0d want byte=%h rises=8",
                             tag, i, frames[i], rises[i], ef[i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_write();
        run_txn(4'h1, 8'h5A, 1'b0, 8'hFF, "write_5a");
        for (int i = 0; i < 3; i++) run_txn(4'($urandom), 8'($urandom), 1'b0, 8'($urandom), "write_rand");
        repeat (5) @(negedge clk);
        total++;
        if (rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL write_hold got %h want 00", rsp_data);
        end
    endtask

    task automatic test_read();
        run_txn(4'h3, 8'h00, 1'b1, 8'hA5, "read_a5");
        for (int i = 0; i < 3; i++) run_txn(4'($urandom), 8'($urandom), 1'b1, 8'($urandom), "read_rand");
    endtask

    task automatic test_back_to_back();
        int busy_bad = 0;
        int lat;
        logic [7:0] m2 = 8'($urandom);
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 4'h2; req_data = 8'h33; req_read = 1'b0;
        @(negedge clk);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 400) begin
            if (req_ready !== 1'b0) busy_bad++;
            @(negedge clk);
            lat++;
        end
        total++;
        if (busy_bad != 0 || req_ready !== 1'b0 || lat != exp_latency(D, G, 1'b0)) begin
            bad++;
            $display("FAIL b2b_first got busy_bad=%0d ready=%b lat=%0d want 0 0 %0d",
                     busy_bad, req_ready, lat, exp_latency(D, G, 1'b0));
        end
        req_cmd = 4'h9; req_data = 8'hC3; req_read = 1'b1; miso_byte = m2;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || SSB !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle got ready=%b ssb=%b want 1 1", req_ready, SSB);
        end
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (SSB !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second_accept got ssb=%b ready=%b want 0 0", SSB, req_ready);
        end
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != exp_latency(D, G, 1'b1) || rsp_data !== m2) begin
            bad++;
            $display("FAIL b2b_second got lat=%0d data=%h want %0d %h",
                     lat, rsp_data, exp_latency(D, G, 1'b1), m2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int n = 0;
        int seen = 0;
        @(negedge clk);
        frames.delete();
        rises.delete();
        req_valid = 1'b1; req_cmd = 4'h4; req_data = 8'hE7; req_read = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!(frames.size() == 1 && rc == 5) && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL abort_reach got timeout want 5th rise of data byte");
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total++;
        if ({SSB, SCK, MOSI, req_ready, rsp_valid} !== 5'b10010) begin
            bad++;
            $display("FAIL abort_state got ssb=%b sck=%b mosi=%b rdy=%b rv=%b want 1 0 0 1 0",
                     SSB, SCK, MOSI, req_ready, rsp_valid);
        end
        repeat (150) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_no_rsp got pulses=%0d ready=%b want 0 1", seen, req_ready);
        end
    endtask

    task automatic test_fast();
        int lat;
        @(negedge clk);
        f_req_valid = 1'b1; f_req_cmd = 4'($urandom); f_req_data = 8'($urandom); f_req_read = 1'b0;
        @(negedge clk);
        f_req_valid = 1'b0;
        lat = 1;
        while (f_rsp_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != exp_latency(FD, FG, 1'b0) || f_rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL fast_write got lat=%0d data=%h want %0d 00",
                     lat, f_rsp_data, exp_latency(FD, FG, 1'b0));
        end
        @(negedge clk);
        total++;
        if (f_viol != 0 || viol != 0) begin
            bad++;
            $display("FAIL ssb_while_sck_high got fast=%0d main=%0d want 0 0", f_viol, viol);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_cmd = 4'h0; req_data = 8'h00; req_read = 1'b0;
        f_req_valid = 1'b0; f_req_cmd = 4'h0; f_req_data = 8'h00; f_req_read = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_abort();
        test_fast();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
